// File: rtl/blctrl_pkg.sv
// Shared types and constants for the brushless-controller sweep scheduler.
// Channel 0 sits in the top byte of the flat speed bus.
package blctrl_pkg;

  localparam int NUM_MOTORS    = 8;
  localparam int CH_W          = 3;
  localparam int IDX_W         = CH_W + 1;
  localparam int SPEED_W       = 8;
  localparam int SPEED_FLAT_W  = NUM_MOTORS * SPEED_W;
  localparam int SPEED_CH0_MSB = SPEED_FLAT_W - 1;

  localparam logic [6:0] DEFAULT_BASE_ADDR = 7'h29;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_CMD_WR    = 3'd2,
    ST_DATA      = 3'd3,
    ST_CMD_STOP  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  function automatic logic [SPEED_W-1:0] speed_of(input logic [SPEED_FLAT_W-1:0] flat,
                                                  input logic [CH_W-1:0] ch);
    return flat[SPEED_CH0_MSB - SPEED_W * int'(ch) -: SPEED_W];
  endfunction

endpackage

// File: rtl/blctrl_next_channel.sv
// Combinational search for the lowest enabled channel at or above start_idx.
// start_idx may be NUM_MOTORS, which always reports nothing found.
module blctrl_next_channel
  import blctrl_pkg::*;
(
  input  logic [NUM_MOTORS-1:0] mask,
  input  logic [IDX_W-1:0]      start_idx,
  output logic                  found,
  output logic [CH_W-1:0]       channel
);

  always_comb begin
    found   = 1'b0;
    channel = '0;
    // Scan downwards so the last hit written is the lowest qualifying channel.
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= start_idx)) begin
        found   = 1'b1;
        channel = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/blctrl_sweep_scheduler.sv
// Drives the i2c_master command/data streams: once per refresh period, each
// enabled channel gets write(BASE_ADDR+n), one speed byte, stop.
module blctrl_sweep_scheduler
  import blctrl_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int         REFRESH_CYCLES = 50000,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_MOTORS-1:0]   motor_enable,
  input  logic [SPEED_FLAT_W-1:0] target_speed_flat,
  output logic [6:0]              cmd_address,
  output logic                    cmd_start,
  output logic                    cmd_write,
  output logic                    cmd_stop,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              data_tdata,
  output logic                    data_tvalid,
  output logic                    data_tlast,
  input  logic                    data_tready,
  input  logic                    master_busy,
  input  logic                    missed_ack,
  input  logic                    clear_errors,
  output logic                    sweep_done,
  output logic [NUM_MOTORS-1:0]   ack_error_mask,
  output logic                    timeout_flag,
  output logic                    overrun_flag
);

  localparam int TMR_W = $clog2(REFRESH_CYCLES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  // Valid/ready: a valid, once raised, stays high with its payload stable
  // until the cycle in which ready is also high; only the watchdog may
  // withdraw it early.

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    pending_q, pending_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic [SPEED_W-1:0]      speed_q, speed_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [6:0]              cmd_address_q, cmd_address_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    cmd_write_q, cmd_write_d;
  logic                    cmd_stop_q, cmd_stop_d;
  logic                    data_tvalid_q, data_tvalid_d;
  logic                    sweep_done_q, sweep_done_d;
  logic [NUM_MOTORS-1:0]   ack_err_q, ack_err_d;
  logic                    timeout_q, timeout_d;
  logic                    overrun_q, overrun_d;

  logic                    timer_wrap;
  logic                    start_sweep;
  logic                    in_txn;
  logic                    wd_expired;
  logic                    nc_found;
  logic [CH_W-1:0]         nc_channel;

  blctrl_next_channel u_next_channel (
    .mask      (motor_enable),
    .start_idx (idx_q),
    .found     (nc_found),
    .channel   (nc_channel)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chan_d        = chan_q;
    speed_d       = speed_q;
    cmd_address_d = cmd_address_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_stop_d    = cmd_stop_q;
    data_tvalid_d = data_tvalid_q;
    sweep_done_d  = 1'b0;

    timer_wrap  = (timer_q == TMR_LAST);
    timer_d     = timer_wrap ? '0 : timer_q + 1'b1;
    start_sweep = (state_q == ST_IDLE) && enable && pending_q;

    pending_d = pending_q;
    if (timer_wrap) begin
      pending_d = 1'b1;
    end else if (start_sweep) begin
      pending_d = 1'b0;
    end

    // Clear first so an error arriving in the same cycle survives.
    ack_err_d = clear_errors ? '0 : ack_err_q;
    timeout_d = clear_errors ? 1'b0 : timeout_q;
    overrun_d = clear_errors ? 1'b0 : overrun_q;
    if (timer_wrap && pending_q && !start_sweep) begin
      overrun_d = 1'b1;
    end

    in_txn     = (state_q inside {ST_CMD_WR, ST_DATA, ST_CMD_STOP, ST_WAIT_DONE});
    wd_d       = in_txn ? wd_q + 1'b1 : wd_q;
    wd_expired = in_txn && (wd_q == WD_LAST);

    if (in_txn && missed_ack) begin
      ack_err_d[chan_q] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_sweep) begin
          idx_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!nc_found) begin
          sweep_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          chan_d        = nc_channel;
          speed_d       = speed_of(target_speed_flat, nc_channel);
          cmd_address_d = BASE_ADDR + {4'b0000, nc_channel};
          cmd_valid_d   = 1'b1;
          cmd_write_d   = 1'b1;
          cmd_stop_d    = 1'b0;
          wd_d          = '0;
          state_d       = ST_CMD_WR;
        end
      end
      ST_CMD_WR: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d   = 1'b0;
          cmd_write_d   = 1'b0;
          data_tvalid_d = 1'b1;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_tvalid_q && data_tready) begin
          data_tvalid_d = 1'b0;
          cmd_valid_d   = 1'b1;
          cmd_stop_d    = 1'b1;
          state_d       = ST_CMD_STOP;
        end
      end
      ST_CMD_STOP: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          cmd_stop_d  = 1'b0;
          state_d     = ST_WAIT_DONE;
        end
      end
      default: ;
    endcase

    // Transaction end, normal or aborted: a dropped enable parks in IDLE
    // without a sweep_done, and the next sweep restarts from channel 0.
    if (wd_expired || (state_q == ST_WAIT_DONE && !master_busy)) begin
      cmd_valid_d   = 1'b0;
      cmd_write_d   = 1'b0;
      cmd_stop_d    = 1'b0;
      data_tvalid_d = 1'b0;
      if (wd_expired) begin
        timeout_d = 1'b1;
      end
      if (enable) begin
        idx_d   = {1'b0, chan_q} + 1'b1;
        state_d = ST_SELECT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      chan_q        <= '0;
      speed_q       <= '0;
      wd_q          <= '0;
      cmd_address_q <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_stop_q    <= 1'b0;
      data_tvalid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      ack_err_q     <= '0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      chan_q        <= chan_d;
      speed_q       <= speed_d;
      wd_q          <= wd_d;
      cmd_address_q <= cmd_address_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_stop_q    <= cmd_stop_d;
      data_tvalid_q <= data_tvalid_d;
      sweep_done_q  <= sweep_done_d;
      ack_err_q     <= ack_err_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
    end
  end

  assign cmd_address    = cmd_address_q;
  assign cmd_start      = 1'b0;
  assign cmd_write      = cmd_write_q;
  assign cmd_stop       = cmd_stop_q;
  assign cmd_valid      = cmd_valid_q;
  assign data_tdata     = speed_q;
  assign data_tvalid    = data_tvalid_q;
  assign data_tlast     = data_tvalid_q;
  assign sweep_done     = sweep_done_q;
  assign ack_error_mask = ack_err_q;
  assign timeout_flag   = timeout_q;
  assign overrun_flag   = overrun_q;

endmodule

// File: doc/blctrl_sweep_scheduler.md
Name: blctrl_sweep_scheduler

Overview:
Sequences the shared I2C master command and write-data streams to refresh every enabled brushless motor controller once per refresh period. Each enabled channel gets one transaction: write to BASE_ADDR+index, then one speed byte, then stop. It replaces the free-running single-motor loop in front of i2c_master. It also adds period pacing, per-channel enable masking, ack-error bookkeeping and a transaction watchdog.

Parameters:
NUM_MOTORS, 8, number of channels (fixed 8 in this revision)
BASE_ADDR, 7'h29, I2C address of channel 0; channel n uses BASE_ADDR+n
REFRESH_CYCLES, 50000, clk cycles between sweep starts
TIMEOUT_CYCLES, 4096, max clk cycles one transaction may take

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  master enable for sweeps
motor_enable  in  8  bit n enables channel n
target_speed_flat  in  64  channel 0 in [63:56] … channel 7 in [7:0]
cmd_address  out  7  to i2c_master s_axis_cmd_address
cmd_start  out  1  always 0
cmd_write  out  1  to s_axis_cmd_write
cmd_stop  out  1  to s_axis_cmd_stop
cmd_valid  out  1  to s_axis_cmd_valid
cmd_ready  in  1  from s_axis_cmd_ready
data_tdata  out  8  to s_axis_data_tdata
data_tvalid  out  1  to s_axis_data_tvalid
data_tlast  out  1  to s_axis_data_tlast
data_tready  in  1  from s_axis_data_tready
master_busy  in  1  from i2c_master busy
missed_ack  in  1  from i2c_master missed_ack
clear_errors  in  1  clears ack_error_mask, timeout_flag and overrun_flag
sweep_done  out  1  one-cycle pulse when a sweep finishes
ack_error_mask  out  8  sticky; bit n = channel n NACKed
timeout_flag  out  1  sticky watchdog flag
overrun_flag  out  1  sticky; a refresh tick arrived while a tick was already pending

Behaviour:
- Reset (async): all outputs 0, FSM in IDLE, timer 0, pending 0, idx 0.
- Refresh timer: free-running; wraps at REFRESH_CYCLES-1 and sets pending on wrap.
  - If pending is already 1 at wrap, set overrun_flag.
  - Runs regardless of enable.
- IDLE: when enable && pending, clear pending, set idx=0, go to SELECT.
- SELECT (1 cycle): find the lowest enabled channel >= idx.
  - None found: pulse sweep_done, go to IDLE. An all-zero mask therefore gives sweep_done 1 cycle after start with no bus traffic.
  - Found: latch channel number and speed byte (snapshot; later input changes are ignored), set cmd_address, go to CMD_WR.
- CMD_WR: cmd_valid=1, cmd_write=1, cmd_stop=0. On cmd_valid&&cmd_ready, drop cmd_valid and go to DATA.
- DATA: data_tvalid=1, data_tlast=1, data_tdata=latched speed. On handshake, drop tvalid and go to CMD_STOP.
- CMD_STOP: cmd_valid=1, cmd_write=0, cmd_stop=1. On handshake, go to WAIT_DONE.
- WAIT_DONE: wait for master_busy==0, then set idx=channel+1 and go to SELECT. If channel==7, end the sweep.
- Valid/ready: a valid never drops before its handshake completes, except on watchdog abort.
- missed_ack: while in CMD_WR..WAIT_DONE, a 1 sets ack_error_mask[channel]. The transaction still completes and the sweep continues.
- Watchdog:
  - Counter resets on entering CMD_WR and increments each cycle in CMD_WR..WAIT_DONE.
  - At TIMEOUT_CYCLES: deassert all valids, set timeout_flag, advance as from WAIT_DONE.
- enable drops mid-sweep: finish the current transaction through WAIT_DONE, then go to IDLE without sweep_done. The next sweep restarts at channel 0.
- clear_errors in the same cycle as a new error: the new error bit wins.
- Reset mid-transaction: immediate return to IDLE with valids low. The bus-side recovery belongs to i2c_master.

Decomposition:
- blctrl_pkg holds:
  - the FSM state enum (IDLE, SELECT, CMD_WR, DATA, CMD_STOP, WAIT_DONE);
  - NUM_MOTORS;
  - the default BASE_ADDR;
  - speed-slice index constants.
- One natural sub-module, blctrl_next_channel: combinational search for the lowest set mask bit >= idx, returning a found flag and the channel number.

Test Plan:
- motor_enable=8'hFF, speeds 0x10..0x17, ready always 1 -> 8 transactions at addresses 0x29..0x30 with bytes 0x10..0x17 in order, then one sweep_done pulse.
- motor_enable=8'b0100_0001 -> only addresses 0x29 and 0x2F are transacted; no traffic for the other channels.
- missed_ack pulsed during the channel 1 transaction -> ack_error_mask=8'h02 and the sweep continues. A later clear_errors returns it to 0.
- cmd_ready held 0 after the first command -> timeout_flag set after 4096 cycles, valids drop, the FSM moves to the next channel.
- enable dropped during the channel 3 DATA phase -> the channel 3 stop is still issued, then IDLE, no sweep_done. Re-enable -> next sweep starts at 0x29.
- REFRESH_CYCLES=100 with a stalled bus -> overrun_flag set. Async rst mid-CMD_WR -> all outputs 0 immediately.
